// File: rtl/cpu_checker_fsm.sv
// Passive character-serial checker for CPU trace lines: recognises register-write and
// memory-write log lines and reports line type plus field-range errors after the '#'.
module cpu_checker_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char,
    output logic [1:0] format_type,
    output logic [3:0] error_code
);

    typedef enum logic [3:0] {
        IDLE, TIME, AT_SEEN, PC, COLON_SP, GRF, ADDR,
        SP1, LT, SP2, DATA, DONE_R, DONE_M
    } state_e;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_LT     = 8'h3C;
    localparam logic [7:0] CH_EQ     = 8'h3D;
    localparam logic [7:0] CH_HASH   = 8'h23;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [13:0] time_q, time_d;
    logic [13:0] grf_q, grf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic        mem_q, mem_d;

    logic        is_dec;
    logic        is_hex;
    logic [3:0]  nib;
    logic        pc_bad;
    logic        addr_bad;
    logic        grf_bad;

    // Only lowercase a-f count as hex letters; 'a'..'f' low nibble 1..6 maps to 10..15.
    always_comb begin
        is_dec = (char >= 8'h30) && (char <= 8'h39);
        is_hex = is_dec || ((char >= 8'h61) && (char <= 8'h66));
        nib    = is_dec ? char[3:0] : (char[3:0] + 4'd9);
    end

    // NOTE: every variable gets a default first so no path leaves a value unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        time_d  = time_q;
        grf_d   = grf_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        mem_d   = mem_q;

        if (char == CH_CARET) begin
            state_d = TIME;
            cnt_d   = 4'd0;
            time_d  = 14'd0;
        end else begin
            state_d = IDLE;
            case (state_q)
                TIME: begin
                    if (is_dec && cnt_q < 4'd4) begin
                        state_d = TIME;
                        cnt_d   = cnt_q + 4'd1;
                        time_d  = time_q * 14'd10 + {10'd0, nib};
                    end else if (char == CH_AT && cnt_q != 4'd0) begin
                        state_d = AT_SEEN;
                    end
                end
                AT_SEEN: begin
                    if (is_hex) begin
                        state_d = PC;
                        cnt_d   = 4'd1;
                        pc_d    = {pc_q[27:0], nib};
                    end
                end
                PC: begin
                    if (is_hex && cnt_q < 4'd8) begin
                        state_d = PC;
                        cnt_d   = cnt_q + 4'd1;
                        pc_d    = {pc_q[27:0], nib};
                    end else if (char == CH_COLON && cnt_q == 4'd8) begin
                        state_d = COLON_SP;
                    end
                end
                COLON_SP: begin
                    if (char == CH_SPACE) begin
                        state_d = COLON_SP;
                    end else if (char == CH_DOLLAR) begin
                        state_d = GRF;
                        cnt_d   = 4'd0;
                        grf_d   = 14'd0;
                        mem_d   = 1'b0;
                    end else if (char == CH_STAR) begin
                        state_d = ADDR;
                        cnt_d   = 4'd0;
                        mem_d   = 1'b1;
                    end
                end
                GRF: begin
                    if (is_dec && cnt_q < 4'd4) begin
                        state_d = GRF;
                        cnt_d   = cnt_q + 4'd1;
                        grf_d   = grf_q * 14'd10 + {10'd0, nib};
                    end else if (char == CH_SPACE && cnt_q != 4'd0) begin
                        state_d = SP1;
                    end else if (char == CH_LT && cnt_q != 4'd0) begin
                        state_d = LT;
                    end
                end
                ADDR: begin
                    if (is_hex && cnt_q < 4'd8) begin
                        state_d = ADDR;
                        cnt_d   = cnt_q + 4'd1;
                        addr_d  = {addr_q[27:0], nib};
                    end else if (char == CH_SPACE && cnt_q == 4'd8) begin
                        state_d = SP1;
                    end else if (char == CH_LT && cnt_q == 4'd8) begin
                        state_d = LT;
                    end
                end
                SP1: begin
                    if (char == CH_SPACE)   state_d = SP1;
                    else if (char == CH_LT) state_d = LT;
                end
                LT: begin
                    if (char == CH_EQ) state_d = SP2;
                end
                SP2: begin
                    if (char == CH_SPACE) begin
                        state_d = SP2;
                    end else if (is_hex) begin
                        state_d = DATA;
                        cnt_d   = 4'd1;
                    end
                end
                DATA: begin
                    if (is_hex && cnt_q < 4'd8) begin
                        state_d = DATA;
                        cnt_d   = cnt_q + 4'd1;
                    end else if (char == CH_HASH && cnt_q == 4'd8) begin
                        state_d = mem_q ? DONE_M : DONE_R;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            time_q  <= 14'd0;
            grf_q   <= 14'd0;
            pc_q    <= 32'd0;
            addr_q  <= 32'd0;
            mem_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            time_q  <= time_d;
            grf_q   <= grf_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            mem_q   <= mem_d;
        end
    end

    // Fields are frozen from the '#' onwards, so DONE_* decodes them directly.
    always_comb begin
        pc_bad      = (pc_q < 32'h0000_3000) || (pc_q > 32'h0000_4fff) || (pc_q[1:0] != 2'b00);
        addr_bad    = (addr_q > 32'h0000_2fff) || (addr_q[1:0] != 2'b00);
        grf_bad     = (grf_q > 14'd31);
        format_type = 2'b00;
        error_code  = 4'b0000;
        case (state_q)
            DONE_R: begin
                format_type = 2'b01;
                error_code  = {grf_bad, 1'b0, pc_bad, time_q[0]};
            end
            DONE_M: begin
                format_type = 2'b10;
                error_code  = {1'b0, addr_bad, pc_bad, time_q[0]};
            end
            default: begin
                format_type = 2'b00;
                error_code  = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_checker_fsm.sv
// Bench for cpu_checker_fsm: directed trace lines plus randomised lines, each cycle
// compared against a string-level parser of the line grammar.
module tb_cpu_checker_fsm;

    logic       clk;
    logic       reset;
    logic [7:0] ch;
    logic [1:0] format_type;
    logic [3:0] error_code;

    int checks = 0;
    int errors = 0;
    string m_buf = "";

    cpu_checker_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .char        (ch),
        .format_type (format_type),
        .error_code  (error_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_dec(input byte c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit is_hex(input byte c);
        return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    function automatic logic [3:0] hex_val(input byte c);
        int v;
        v = is_dec(c) ? (int'(c) - 48) : (int'(c) - 87);
        return v[3:0];
    endfunction

    // Whole-line grammar check on the text collected since the last '^'.
    function automatic void parse_line(input string s, output logic [1:0] ft, output logic [3:0] ec);
        int i, n, len, t, grf;
        logic [31:0] pc, addr;
        bit mem;
        ft = 2'b00; ec = 4'b0000;
        len = s.len(); i = 1; t = 0; grf = 0; pc = 0; addr = 0; mem = 0;
        if (len == 0 || s[0] != 8'h5E) return;
        n = 0;
        while (i < len && is_dec(s[i])) begin t = t * 10 + int'(s[i]) - 48; i++; n++; end
        if (n < 1 || n > 4 || i >= len || s[i] != 8'h40) return;
        i++; n = 0;
        while (i < len && is_hex(s[i])) begin pc = {pc[27:0], hex_val(s[i])}; i++; n++; end
        if (n != 8 || i >= len || s[i] != 8'h3A) return;
        i++;
        while (i < len && s[i] == 8'h20) i++;
        if (i >= len) return;
        if (s[i] == 8'h24) begin
            i++; n = 0;
            while (i < len && is_dec(s[i])) begin grf = grf * 10 + int'(s[i]) - 48; i++; n++; end
            if (n < 1 || n > 4) return;
        end else if (s[i] == 8'h2A) begin
            mem = 1; i++; n = 0;
            while (i < len && is_hex(s[i])) begin addr = {addr[27:0], hex_val(s[i])}; i++; n++; end
            if (n != 8) return;
        end else return;
        while (i < len && s[i] == 8'h20) i++;
        if (i + 1 >= len || s[i] != 8'h3C || s[i+1] != 8'h3D) return;
        i += 2;
        while (i < len && s[i] == 8'h20) i++;
        n = 0;
        while (i < len && is_hex(s[i])) begin i++; n++; end
        if (n != 8 || i != len - 1 || s[i] != 8'h23) return;
        ft    = mem ? 2'b10 : 2'b01;
        ec[0] = (t % 2) == 1;
        ec[1] = (pc < 32'h3000) || (pc > 32'h4fff) || (pc % 4 != 0);
        ec[2] = mem && ((addr > 32'h2fff) || (addr % 4 != 0));
        ec[3] = !mem && (grf > 31);
    endfunction

    task automatic model_step(input byte c, output logic [1:0] ft, output logic [3:0] ec);
        ft = 2'b00; ec = 4'b0000;
        if (c == 8'h5E) m_buf = "^";
        else if (m_buf.len() != 0) m_buf = $sformatf("%s%c", m_buf, (c == 8'h00) ? 8'h7E : c);
        if (c == 8'h23) parse_line(m_buf, ft, ec);
    endtask

    task automatic check_out(input string tag, input logic [1:0] eft, input logic [3:0] eec);
        checks++;
        assert (format_type === eft) else begin
            errors++;
            $error("FAIL %s format_type: got %b expected %b", tag, format_type, eft);
        end
        checks++;
        assert (error_code === eec) else begin
            errors++;
            $error("FAIL %s error_code: got %b expected %b", tag, error_code, eec);
        end
    endtask

    task automatic send_char(input byte c, input string tag);
        logic [1:0] eft;
        logic [3:0] eec;
        @(negedge clk);
        ch = c;
        @(posedge clk);
        #1;
        model_step(c, eft, eec);
        check_out(tag, eft, eec);
    endtask

    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) send_char(s[i], tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b0;
        ch = 8'($urandom);
        @(posedge clk);
        #1;
        m_buf = "";
        check_out(tag, 2'b00, 4'b0000);
        reset = 1'b1;
    endtask

    function automatic string spaces(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = {s, " "};
        return s;
    endfunction

    function automatic string rand_line();
        string s, tstr, alpha;
        int nd, p;
        logic [31:0] pc;
        alpha = "0123456789abcdefAFB$*@:<=# ^x";
        nd = $urandom_range(1, 4);
        if ($urandom_range(0, 15) == 0) nd = ($urandom_range(0, 1) == 0) ? 0 : 5;
        tstr = "";
        for (int i = 0; i < nd; i++) tstr = $sformatf("%s%0d", tstr, $urandom_range(0, 9));
        pc = ($urandom_range(0, 7) == 0) ? $urandom : (32'h2ff0 + $urandom_range(0, 32'h2030));
        s = $sformatf("^%s@%08h:%s", tstr, pc, spaces($urandom_range(0, 2)));
        if ($urandom_range(0, 1) == 0)
            s = $sformatf("%s$%0d", s, $urandom_range(0, 63));
        else
            s = $sformatf("%s*%08h", s, $urandom_range(0, 32'h3010));
        s = $sformatf("%s%s<=%s%08h#", s, spaces($urandom_range(0, 2)),
                      spaces($urandom_range(0, 2)), $urandom);
        if ($urandom_range(0, 3) == 0) begin
            p = $urandom_range(1, s.len() - 1);
            s.putc(p, alpha[$urandom_range(0, alpha.len() - 1)]);
        end
        return s;
    endfunction

    initial begin
        reset = 1'b0;
        ch    = 8'h00;
        do_reset("reset_state");
        send_char(8'h20, "idle_after_reset");

        send_str("^242@000030f4: $31 <=12345678#", "reg_ok");
        check_out("reg_ok_done", 2'b01, 4'b0000);
        send_char(8'h78, "reg_ok_drop");
        check_out("reg_ok_drop_const", 2'b00, 4'b0000);

        send_str("^242@000030f4: $ <=12345678#", "missing_grf");
        check_out("missing_grf_const", 2'b00, 4'b0000);
        send_str("^242@000030f4: $31 <=   123215 #", "short_data");
        check_out("short_data_const", 2'b00, 4'b0000);

        send_str("^338@00003130: *00000088 <= ffffb528#", "mem_ok");
        check_out("mem_ok_done", 2'b10, 4'b0000);
        send_str("^338@00003130: *00000088 <= Ffffb528#", "upper_f");
        check_out("upper_f_const", 2'b00, 4'b0000);
        send_str("^338@00003130: *00000088 <= ffffB528#", "upper_b");
        check_out("upper_b_const", 2'b00, 4'b0000);
        send_str("^338@00003130: *00000088 <= ffffb52B#", "upper_last");
        check_out("upper_last_const", 2'b00, 4'b0000);
        send_str("^338@00003130: *00000088 <= ffffb52800#", "data10");
        check_out("data10_const", 2'b00, 4'b0000);
        send_str("^338@00003130: *00000088 <= ffffb52#", "data7");
        check_out("data7_const", 2'b00, 4'b0000);

        // back-to-back: the second line starts on the cycle the first one reports
        send_str("^7@00005001: $40 <=00000000#", "reg_err");
        check_out("reg_err_done", 2'b01, 4'b1011);
        send_str("^8@00003000: *00003002 <=00000000#", "mem_err");
        check_out("mem_err_done", 2'b10, 4'b0100);

        send_str("^12@0000", "abort_pre");
        do_reset("abort_reset");
        send_str("3000: $1 <=00000000#", "abort_post");
        check_out("abort_post_const", 2'b00, 4'b0000);
        send_str("^4@00004ffc: $0 <=0000abcd#", "after_abort");
        check_out("after_abort_done", 2'b01, 4'b0000);
        send_str("^1^2@00003000: $1 <=00000000#", "restart");
        check_out("restart_done", 2'b01, 4'b0000);
        send_str("^9999@00003000: *00002ffc <=00000000#", "bounds_hi");
        check_out("bounds_hi_done", 2'b10, 4'b0001);
        send_str("^0@00002ffc: $9999 <=00000000#", "bounds_lo");
        check_out("bounds_lo_done", 2'b01, 4'b1010);

        for (int n = 0; n < 150; n++) begin
            send_str(rand_line(), "random");
            if ($urandom_range(0, 19) == 0) do_reset("random_reset");
            for (int g = $urandom_range(0, 3); g > 0; g--)
                send_char(($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(8'h20, 8'h7e)),
                          "garbage");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
